// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand selection and
// load-use hazard detection for the 5-stage RV32I pipeline.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_sel,
  input  logic        id_a_sel,
  input  logic        id_b_sel,
  input  logic        id_reg_wen,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        flush,
  input  logic        hold,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_wen,
  input  logic [31:0] mem_fwd_data,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_wen,
  input  logic [31:0] wb_data,
  output logic        load_use_stall,
  output logic        ex_valid,
  output logic        ex_reg_wen,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic [3:0]  ex_alu_sel,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [31:0] ex_store_data
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;
  logic [31:0] imm_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [4:0]  rd_q;
  logic [3:0]  alu_sel_q;
  logic        a_sel_q;
  logic        b_sel_q;
  logic        reg_wen_q;
  logic        mem_read_q;
  logic        mem_write_q;

  // Decode bypass: the register file has no write-through, so a value being
  // written back this cycle must be picked up directly on capture.
  logic        wb_live;
  logic [31:0] rs1_capture;
  logic [31:0] rs2_capture;

  always_comb begin
    wb_live     = wb_reg_wen && (wb_rd != 5'd0);
    rs1_capture = (wb_live && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
    rs2_capture = (wb_live && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;
  end

  // Load-use hazard: a load in EX whose result an ID operand actually consumes.
  logic load_in_ex;
  logic rs1_hazard;
  logic rs2_hazard;

  always_comb begin
    load_in_ex     = valid_q && mem_read_q && (rd_q != 5'd0);
    rs1_hazard     = (id_rs1 == rd_q) && !id_a_sel;
    rs2_hazard     = (id_rs2 == rd_q) && (!id_b_sel || id_mem_write);
    load_use_stall = load_in_ex && id_valid && (rs1_hazard || rs2_hazard) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      alu_sel_q   <= 4'd0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      reg_wen_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (flush || (!hold && load_use_stall)) begin
      // Bubble: every field zeroed so an invalid slot can never write or forward.
      valid_q     <= 1'b0;
      pc_q        <= 32'd0;
      rs1_data_q  <= 32'd0;
      rs2_data_q  <= 32'd0;
      imm_q       <= 32'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      rd_q        <= 5'd0;
      alu_sel_q   <= 4'd0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      reg_wen_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!hold) begin
      valid_q     <= id_valid;
      pc_q        <= id_pc;
      rs1_data_q  <= rs1_capture;
      rs2_data_q  <= rs2_capture;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      alu_sel_q   <= id_alu_sel;
      a_sel_q     <= id_a_sel;
      b_sel_q     <= id_b_sel;
      reg_wen_q   <= id_reg_wen;
      mem_read_q  <= id_mem_read;
      mem_write_q <= id_mem_write;
    end
  end

  // Forwarding: the younger result in MEM wins over WB; x0 is never forwarded.
  logic        mem_live;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;

  always_comb begin
    mem_live = mem_reg_wen && (mem_rd != 5'd0);
    if (mem_live && (mem_rd == rs1_q)) begin
      fwd_rs1 = mem_fwd_data;
    end else if (wb_live && (wb_rd == rs1_q)) begin
      fwd_rs1 = wb_data;
    end else begin
      fwd_rs1 = rs1_data_q;
    end
    if (mem_live && (mem_rd == rs2_q)) begin
      fwd_rs2 = mem_fwd_data;
    end else if (wb_live && (wb_rd == rs2_q)) begin
      fwd_rs2 = wb_data;
    end else begin
      fwd_rs2 = rs2_data_q;
    end
  end

  always_comb begin
    ex_alu_a      = a_sel_q ? pc_q : fwd_rs1;
    ex_alu_b      = b_sel_q ? imm_q : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

  assign ex_valid     = valid_q;
  assign ex_reg_wen   = reg_wen_q;
  assign ex_mem_read  = mem_read_q;
  assign ex_mem_write = mem_write_q;
  assign ex_pc        = pc_q;
  assign ex_rd        = rd_q;
  assign ex_alu_sel   = alu_sel_q;

endmodule
